// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: load/store size encodings and the memory-stage FSM states.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_W:         mis = (offset != 2'b00);
            F3_H, F3_HU:  mis = offset[0];
            default:      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign/zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension
    always_comb begin
        byte_s = rdata_i[{offset_i, 3'b000} +: 8];
        half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'h000000, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'h0000, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues req/gnt/rvalid bus transactions for loads/stores,
// stalls upstream while one is outstanding, and registers the writeback payload.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rs2_val,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_mem_read,
    input  logic        mem_mem_write,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_misalign,
    output logic        mem_bus_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        is_load_s, is_store_s, mem_op_s, misalign_s, timeout_s;
    logic [31:0] st_wdata_s;
    logic [3:0]  st_wstrb_s;
    logic [31:0] load_data_s;

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (load_data_s)
    );

    // Store lane replication and byte enables from the current EX/MEM address
    always_comb begin
        st_wdata_s = mem_rs2_val;
        st_wstrb_s = 4'b1111;
        case (mem_funct3)
            F3_B: begin
                st_wdata_s = {4{mem_rs2_val[7:0]}};
                st_wstrb_s = 4'b0001 << mem_alu_result[1:0];
            end
            F3_H: begin
                st_wdata_s = {2{mem_rs2_val[15:0]}};
                st_wstrb_s = mem_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata_s = mem_rs2_val;
                st_wstrb_s = 4'b1111;
            end
        endcase
    end

    // A read+write combination is serviced as a load only
    assign is_load_s  = mem_mem_read;
    assign is_store_s = mem_mem_write & ~mem_mem_read;
    assign mem_op_s   = is_load_s | is_store_s;
    assign misalign_s = mem_op_s & is_misaligned(mem_funct3, mem_alu_result[1:0]);
    assign timeout_s  = (state_q != ST_IDLE) && (cnt_q == CW'(MAX_WAIT));

    // FSM next state, bus drive, stall and writeback payload
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        we_d           = we_q;
        rw_d           = rw_q;
        m2r_d          = m2r_q;
        dmem_req       = 1'b0;
        dmem_we        = we_q;
        dmem_addr      = {addr_q[31:2], 2'b00};
        dmem_wdata     = wdata_q;
        dmem_wstrb     = wstrb_q;
        mem_stall      = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (misalign_s) begin
                    misalign_d = 1'b1;
                end else if (mem_op_s) begin
                    dmem_req   = 1'b1;
                    dmem_we    = is_store_s;
                    dmem_addr  = {mem_alu_result[31:2], 2'b00};
                    dmem_wdata = st_wdata_s;
                    dmem_wstrb = is_store_s ? st_wstrb_s : 4'b0000;
                    rd_d       = mem_rd;
                    f3_d       = mem_funct3;
                    addr_d     = mem_alu_result;
                    wdata_d    = st_wdata_s;
                    wstrb_d    = is_store_s ? st_wstrb_s : 4'b0000;
                    we_d       = is_store_s;
                    rw_d       = mem_reg_write;
                    m2r_d      = mem_mem_to_reg;
                    if (!dmem_gnt) begin
                        state_d   = ST_REQ;
                        mem_stall = 1'b1;
                    end else if (is_load_s) begin
                        state_d   = ST_RESP;
                        mem_stall = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    wb_reg_write_d = mem_reg_write & (mem_rd != 5'd0);
                    wb_rd_d        = mem_rd;
                    wb_data_d      = mem_alu_result;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout_s) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (dmem_gnt && we_q) begin
                        state_d   = ST_IDLE;
                        mem_stall = 1'b0;
                    end else if (dmem_gnt) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (timeout_s) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end else if (dmem_rvalid) begin
                    state_d        = ST_IDLE;
                    wb_reg_write_d = rw_q & (rd_q != 5'd0);
                    wb_rd_d        = rd_q;
                    wb_data_d      = m2r_q ? load_data_s : addr_q;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_IDLE) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, transaction latches and writeback register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= {CW{1'b0}};
            rd_q           <= 5'd0;
            f3_q           <= 3'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            wstrb_q        <= 4'd0;
            we_q           <= 1'b0;
            rw_q           <= 1'b0;
            m2r_q          <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'd0;
            misalign_q     <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= rd_d;
            f3_q           <= f3_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            we_q           <= we_d;
            rw_q           <= rw_d;
            m2r_q          <= m2r_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            misalign_q     <= misalign_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign mem_misalign = misalign_q;
    assign mem_bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a default-timeout instance plus a MAX_WAIT=4 instance for the abort path.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_alu_result, mem_rs2_val, dmem_rdata;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
    logic        dmem_gnt, dmem_rvalid;

    logic        req, we, stall, wbw, mis, berr;
    logic [31:0] addr, wdata, wbd;
    logic [3:0]  wstrb;
    logic [4:0]  wbrd;

    logic        req4, we4, stall4, wbw4, mis4, berr4;
    logic [31:0] addr4, wdata4, wbd4;
    logic [3:0]  wstrb4;
    logic [4:0]  wbrd4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(255)) dut (
        .clk(clk), .reset(reset),
        .mem_alu_result(mem_alu_result), .mem_rs2_val(mem_rs2_val), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .dmem_req(req), .dmem_we(we), .dmem_addr(addr), .dmem_wdata(wdata), .dmem_wstrb(wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(stall), .wb_reg_write(wbw), .wb_rd(wbrd), .wb_data(wbd),
        .mem_misalign(mis), .mem_bus_err(berr)
    );

    mem_stage #(.MAX_WAIT(4)) dut4 (
        .clk(clk), .reset(reset),
        .mem_alu_result(mem_alu_result), .mem_rs2_val(mem_rs2_val), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .dmem_req(req4), .dmem_we(we4), .dmem_addr(addr4), .dmem_wdata(wdata4), .dmem_wstrb(wstrb4),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_stall(stall4), .wb_reg_write(wbw4), .wb_rd(wbrd4), .wb_data(wbd4),
        .mem_misalign(mis4), .mem_bus_err(berr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_alu_result = 32'd0;
        mem_rs2_val    = 32'd0;
        mem_rd         = 5'd0;
        mem_funct3     = 3'd0;
        mem_mem_read   = 1'b0;
        mem_mem_write  = 1'b0;
        mem_reg_write  = 1'b0;
        mem_mem_to_reg = 1'b0;
        dmem_gnt       = 1'b0;
        dmem_rvalid    = 1'b0;
        dmem_rdata     = 32'd0;
    endtask

    task automatic load(input logic [31:0] a, input logic [4:0] rd, input logic [2:0] f3, input logic gnt);
        idle();
        mem_alu_result = a;
        mem_rd         = rd;
        mem_funct3     = f3;
        mem_mem_read   = 1'b1;
        mem_reg_write  = 1'b1;
        mem_mem_to_reg = 1'b1;
        dmem_gnt       = gnt;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk("rst_wbw", 32'(wbw), 32'd0);
        chk("rst_wbd", wbd, 32'd0);
        chk("rst_mis", 32'(mis), 32'd0);
        chk("rst_berr", 32'(berr), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Non-memory pass-through, then rd==0 suppression
        @(negedge clk);
        idle(); mem_alu_result = 32'h0000_1234; mem_rd = 5'd3; mem_reg_write = 1'b1;
        #1 chk("alu_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("alu_wbd", wbd, 32'h0000_1234);
        chk("alu_wbrd", 32'(wbrd), 32'd3);
        chk("alu_wbw", 32'(wbw), 32'd1);
        @(negedge clk);
        mem_rd = 5'd0;
        @(posedge clk); #1;
        chk("rd0_wbw", 32'(wbw), 32'd0);
        @(negedge clk);
        mem_rd = 5'd3;
        @(posedge clk); #1;
        chk("alu2_wbw", 32'(wbw), 32'd1);

        // SW with same-cycle grant
        @(negedge clk);
        idle(); mem_alu_result = 32'h100; mem_rs2_val = 32'hDEAD_BEEF; mem_funct3 = F3_W;
        mem_mem_write = 1'b1; dmem_gnt = 1'b1;
        #1;
        chk("sw_req", 32'(req), 32'd1);
        chk("sw_we", 32'(we), 32'd1);
        chk("sw_wstrb", 32'(wstrb), 32'hF);
        chk("sw_addr", addr, 32'h100);
        chk("sw_wdata", wdata, 32'hDEAD_BEEF);
        chk("sw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("sw_wbw", 32'(wbw), 32'd0);

        // LB rd=5 @0x203
        @(negedge clk);
        load(32'h203, 5'd5, F3_B, 1'b1);
        #1;
        chk("lb_stall0", 32'(stall), 32'd1);
        chk("lb_addr", addr, 32'h200);
        chk("lb_we", 32'(we), 32'd0);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8011_2233;
        #1;
        chk("lb_stall1", 32'(stall), 32'd0);
        chk("lb_req1", 32'(req), 32'd0);
        @(posedge clk); #1;
        chk("lb_wbrd", 32'(wbrd), 32'd5);
        chk("lb_wbd", wbd, 32'hFFFF_FF80);
        chk("lb_wbw", 32'(wbw), 32'd1);

        // LHU @0x202
        @(negedge clk);
        load(32'h202, 5'd6, F3_HU, 1'b1);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_ABCD;
        @(posedge clk); #1;
        chk("lhu_wbd", wbd, 32'h0000_8001);
        chk("lhu_wbrd", 32'(wbrd), 32'd6);

        // SB 0x5A @0x101
        @(negedge clk);
        idle(); mem_alu_result = 32'h101; mem_rs2_val = 32'h0000_005A; mem_funct3 = F3_B;
        mem_mem_write = 1'b1; dmem_gnt = 1'b1;
        #1;
        chk("sb_wstrb", 32'(wstrb), 32'b0010);
        chk("sb_wdata", wdata, 32'h5A5A_5A5A);
        chk("sb_addr", addr, 32'h100);
        chk("sb_stall", 32'(stall), 32'd0);

        // LW @0x40: gnt withheld three cycles, rvalid two cycles after gnt
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) load(32'h40, 5'd7, F3_W, 1'b0);
            dmem_gnt = (c == 3);
            #1;
            chk("lw_req", 32'(req), 32'd1);
            chk("lw_addr", addr, 32'h40);
            chk("lw_stall", 32'(stall), 32'd1);
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("lw_req_resp", 32'(req), 32'd0);
        chk("lw_stall4", 32'(stall), 32'd1);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1 chk("lw_stall5", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("lw_wbd", wbd, 32'hCAFE_F00D);
        chk("lw_wbrd", 32'(wbrd), 32'd7);
        chk("lw_wbw", 32'(wbw), 32'd1);

        // Misaligned LW @0x102
        @(negedge clk);
        load(32'h102, 5'd8, F3_W, 1'b1);
        #1;
        chk("mis_req", 32'(req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse", 32'(mis), 32'd1);
        chk("mis_wbw", 32'(wbw), 32'd0);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        chk("mis_clear", 32'(mis), 32'd0);

        // Timeout on the MAX_WAIT=4 instance: load granted, rvalid never comes
        @(negedge clk);
        load(32'h80, 5'd9, F3_W, 1'b1);
        #1 chk("to_stall0", 32'(stall4), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            #1 chk("to_stall_wait", 32'(stall4), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("to_stall_drop", 32'(stall4), 32'd0);
        chk("to_req", 32'(req4), 32'd0);
        chk("to_main_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        chk("to_berr", 32'(berr4), 32'd1);
        chk("to_wbw", 32'(wbw4), 32'd0);

        // Reset while the default instance sits in RESP; late rvalid afterwards
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("mrst_wbw", 32'(wbw), 32'd0);
        chk("mrst_wbd", wbd, 32'd0);
        chk("mrst_wbrd", 32'(wbrd), 32'd0);
        chk("mrst_stall", 32'(stall), 32'd0);
        chk("mrst_berr4", 32'(berr4), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        #1;
        chk("late_stall", 32'(stall), 32'd0);
        chk("late_req", 32'(req), 32'd0);
        @(posedge clk); #1;
        chk("late_wbw", 32'(wbw), 32'd0);
        chk("late_wbd", wbd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
